fc_spk_sched: RTL
=================

// Module: fc_spk_sched
// PURPOSE
//  Upstream scheduler for one FC neuron core. Buffers one time step of input spike addresses.
//  For each of LAYER_SIZE time-multiplexed neurons, it replays the buffer into the core.
//  It then fires activation, samples post_syn_spk and emits a per-neuron result.
//  Sits between the previous layer's spike-event stream and the FC neuron core.
// PARAMETERS
//  IN_CHANNELS      2   input channels of the FC layer
//  INPUT_FRAME_SIZE 28  input positions per channel
//  LAYER_SIZE       10  neurons served by the attached core
//  localparam ADDR_W = $clog2(IN_CHANNELS*INPUT_FRAME_SIZE); DEPTH = IN_CHANNELS*INPUT_FRAME_SIZE
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset, synchronous, active-low
//  in_valid       in   1        input spike event valid
//  in_ready       out  1        scheduler accepts event / ts_done
//  in_addr        in   ADDR_W   presynaptic spike address
//  ts_done        in   1        end of time step; taken with in_ready; may coincide with final event beat
//  ts_last        in   1        qualifies ts_done: this is the sample's final time step
//  en_accum       out  1        core: start accumulation (1-cycle pulse)
//  en_activ       out  1        core: apply bias/threshold (1-cycle pulse)
//  last_time_step out  1        core: clear membrane after activation
//  neuron         out  $clog2(LAYER_SIZE)  neuron index being processed
//  spk_addr       out  ADDR_W   replayed spike address
//  post_syn_spk   in   1        core output spike
//  out_valid      out  1        result pulse
//  out_neuron     out  $clog2(LAYER_SIZE)  neuron index of result
//  out_spk        out  1        spike result
//  out_last       out  1        result belongs to final time step
//  overflow       out  1        sticky: event dropped (buffer full)
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - all outputs 0; state FILL; write/read pointers 0; overflow 0.
//   - Mid-operation reset aborts processing; the buffer is discarded.
//  States:
//   - FILL: in_ready=1.
//     - Each in_valid beat writes in_addr at wptr and increments wptr.
//     - On ts_done: latch ts_last into last_time_step, neuron=0 -> START. A same-cycle event beat is included.
//   - START: en_accum=1, rptr=0 -> ACCUM; if wptr==0 go directly to ACTIV next cycle.
//   - ACCUM: spk_addr=buf[rptr] for exactly one cycle per entry, in write order.
//     - After entry wptr-1 -> ACTIV.
//   - ACTIV: en_activ=1 for one cycle -> WAIT1 -> SAMPLE.
//   - SAMPLE (en_activ+2): register post_syn_spk to out_spk; out_valid=1; out_neuron=neuron; out_last=last_time_step.
//     - neuron<LAYER_SIZE-1: neuron++ -> START (the core is idle this cycle).
//     - Otherwise: wptr=0, last_time_step=0 -> FILL.
//  in_ready=0 in every state except FILL. Events and ts_done are held off upstream via backpressure.
//  Buffer full (wptr==DEPTH) with in_valid=1: event dropped, overflow set (cleared only by reset), in_ready stays 1.
//  Zero-spike step still produces LAYER_SIZE results (leak/bias only).
//  Per-neuron latency: 1 (START) + N (ACCUM) + 1 (ACTIV) + 1 (WAIT1) + 1 (SAMPLE) = N+4 cycles.
//  Step total: LAYER_SIZE*(N+4) cycles.
//  en_accum/en_activ never both high; spk_addr holds last value when unused.
//  neuron and spk_addr are registered outputs.
// STRUCTURE
//  - fc_pkg: sched_state_e (FILL, START, ACCUM, ACTIV, WAIT1, SAMPLE), ADDR_W/DEPTH helper functions.
//  - Sub-module spk_event_buf: DEPTH x ADDR_W register array, 1 write port.
//    - Combinational read at rptr, wptr/full flag.
//  - The FSM and neuron counter live in fc_spk_sched.
// TESTING
//  1. Events 5, 17, 40 then ts_done (LAYER_SIZE=10)
//     -> 10x [en_accum; spk_addr 5, 17, 40 on consecutive cycles; en_activ];
//     -> out_neuron 0..9, each 7 cycles apart.
//  2. ts_done with no events -> en_accum then en_activ next cycle; 10 results; spk_addr unchanged.
//  3. Core model spikes only for neuron 3 -> out_spk=1 only with out_neuron=3.
//     -> Sampled exactly 2 cycles after that en_activ.
//  4. 57 events (DEPTH=56) -> 56 replayed per neuron; overflow=1 and stays 1 across the next step.
//  5. in_valid held during processing -> in_ready=0 until return to FILL.
//     -> Event 9 accepted on that first FILL cycle.
//  6. ts_last=1 -> last_time_step=1 through all 10 neurons, out_last=1, cleared after neuron 9.
//     -> rst=0 mid-ACCUM: next cycle all outputs 0, state FILL.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the FC spike scheduler.
// Depth/width helpers keep buffer and pointer sizing consistent across files.
package fc_pkg;

   typedef enum logic [2:0] {
      FILL,
      START,
      ACCUM,
      ACTIV,
      WAIT1,
      SAMPLE
   } sched_state_e;

   function automatic int buf_depth(input int channels, input int frame_size);
      return channels * frame_size;
   endfunction

   // Index width for a range of n values; never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Pointers must also represent the "full" count itself.
   function automatic int ptr_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/spk_event_buf.sv
// Spike-address buffer: single write port, combinational read at rptr.
// Holds one time step of events; wptr doubles as the stored-entry count.
module spk_event_buf
   import fc_pkg::*;
#(
   parameter int DEPTH  = 56,
   parameter int ADDR_W = idx_width(DEPTH),
   parameter int PTR_W  = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              clr,
   input  logic [ADDR_W-1:0] wr_data,
   input  logic [PTR_W-1:0]  rptr,
   output logic [ADDR_W-1:0] rd_data,
   output logic [PTR_W-1:0]  wptr,
   output logic              full
);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] rd_idx;

   assign full = (wptr == PTR_W'(DEPTH));

   always_comb begin
      rd_idx = '0;
      if (rptr < PTR_W'(DEPTH)) rd_idx = rptr[ADDR_W-1:0];
   end

   assign rd_data = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
      end else if (clr) begin
         wptr <= '0;
      end else if (wr_en && !full) begin
         wptr <= wptr + PTR_W'(1);
      end
   end

   // Storage is not reset; wptr alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en && !full) mem[wptr[ADDR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/fc_spk_sched.sv
// Scheduler for one time-multiplexed FC neuron core: buffers a time step of
// spike addresses, replays them once per neuron, fires activation and samples the result.
module fc_spk_sched
   import fc_pkg::*;
#(
   parameter int IN_CHANNELS      = 2,
   parameter int INPUT_FRAME_SIZE = 28,
   parameter int LAYER_SIZE       = 10,
   localparam int DEPTH    = buf_depth(IN_CHANNELS, INPUT_FRAME_SIZE),
   localparam int ADDR_W   = idx_width(DEPTH),
   localparam int PTR_W    = ptr_width(DEPTH),
   localparam int NEURON_W = idx_width(LAYER_SIZE)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic                ts_done,
   input  logic                ts_last,
   output logic                en_accum,
   output logic                en_activ,
   output logic                last_time_step,
   output logic [NEURON_W-1:0] neuron,
   output logic [ADDR_W-1:0]   spk_addr,
   input  logic                post_syn_spk,
   output logic                out_valid,
   output logic [NEURON_W-1:0] out_neuron,
   output logic                out_spk,
   output logic                out_last,
   output logic                overflow
);

   localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(LAYER_SIZE - 1);

   sched_state_e      state;
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W-1:0]  wptr;
   logic [ADDR_W-1:0] rd_data;
   logic              full;
   logic              wr_en;
   logic              clr;

   // in_ready is only ever high in FILL, so it doubles as the write qualifier.
   assign wr_en = in_valid & in_ready;
   assign clr   = (state == SAMPLE) && (neuron == LAST_NEURON);

   spk_event_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .PTR_W  (PTR_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .clr     (clr),
      .wr_data (in_addr),
      .rptr    (rptr),
      .rd_data (rd_data),
      .wptr    (wptr),
      .full    (full)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= FILL;
         rptr           <= '0;
         in_ready       <= 1'b0;
         en_accum       <= 1'b0;
         en_activ       <= 1'b0;
         last_time_step <= 1'b0;
         neuron         <= '0;
         spk_addr       <= '0;
         out_valid      <= 1'b0;
         out_neuron     <= '0;
         out_spk        <= 1'b0;
         out_last       <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (in_ready && in_valid && full) overflow <= 1'b1;
               if (in_ready && ts_done) begin
                  last_time_step <= ts_last;
                  neuron         <= '0;
                  rptr           <= '0;
                  en_accum       <= 1'b1;
                  in_ready       <= 1'b0;
                  state          <= START;
               end
            end
            START: begin
               en_accum <= 1'b0;
               if (wptr == '0) begin
                  en_activ <= 1'b1;
                  state    <= ACTIV;
               end else begin
                  spk_addr <= rd_data;
                  rptr     <= PTR_W'(1);
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (rptr == wptr) begin
                  en_activ <= 1'b1;
                  state    <= ACTIV;
               end else begin
                  spk_addr <= rd_data;
                  rptr     <= rptr + PTR_W'(1);
               end
            end
            ACTIV: begin
               en_activ <= 1'b0;
               state    <= WAIT1;
            end
            WAIT1: begin
               state <= SAMPLE;
            end
            SAMPLE: begin
               // post_syn_spk is captured two cycles after the activation pulse.
               out_valid  <= 1'b1;
               out_spk    <= post_syn_spk;
               out_neuron <= neuron;
               out_last   <= last_time_step;
               if (neuron != LAST_NEURON) begin
                  neuron   <= neuron + NEURON_W'(1);
                  rptr     <= '0;
                  en_accum <= 1'b1;
                  state    <= START;
               end else begin
                  last_time_step <= 1'b0;
                  in_ready       <= 1'b1;
                  state          <= FILL;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule
